// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uart_tx serializer between NUM_REQ byte-stream requesters.
// A grant is held for a whole message, until the byte flagged last or until the owner idles too long.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int HOLD_TIMEOUT = 1024
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic [NUM_REQ-1:0]     i_req_valid,
    input  logic [8*NUM_REQ-1:0]   i_req_data,
    input  logic [NUM_REQ-1:0]     i_req_last,
    output logic [NUM_REQ-1:0]     o_req_ready,
    output logic [NUM_REQ-1:0]     o_grant,
    output logic [7:0]             o_tx_data,
    output logic                   o_tx_stb,
    input  logic                   i_tx_busy
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TW = (HOLD_TIMEOUT > 1) ? $clog2(HOLD_TIMEOUT) : 1;
    localparam logic [TW-1:0] T_LAST = (HOLD_TIMEOUT > 0) ? TW'(HOLD_TIMEOUT - 1) : '0;

    typedef enum logic [2:0] {
        S_ARB        = 3'd0,
        S_XFER       = 3'd1,
        S_STB        = 3'd2,
        S_WAIT_START = 3'd3,
        S_WAIT_IDLE  = 3'd4
    } state_e;

    state_e               state_q, state_d;
    logic [PW-1:0]        ptr_q, ptr_d;
    logic [PW-1:0]        owner_q, owner_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [7:0]           data_q, data_d;
    logic                 last_q, last_d;
    logic                 stb_q, stb_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [PW:0]          pick_s;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] k);
        if (k == PW'(NUM_REQ - 1)) begin
            return '0;
        end else begin
            return k + PW'(1);
        end
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input logic [PW-1:0] k);
        logic [NUM_REQ-1:0] v;
        v    = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    // Scan from ptr upward; iterating backwards lets the smallest offset win.
    function automatic logic [PW:0] rr_pick(input logic [NUM_REQ-1:0] valid, input logic [PW-1:0] ptr);
        logic [PW:0] res;
        int          idx;
        res = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (valid[idx]) res = {1'b1, PW'(idx)};
        end
        return res;
    endfunction

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        grant_d = grant_q;
        data_d  = data_q;
        last_d  = last_q;
        timer_d = timer_q;
        stb_d   = 1'b0;
        pick_s  = rr_pick(i_req_valid, ptr_q);
        case (state_q)
            S_ARB: begin
                if (pick_s[PW] && !i_tx_busy) begin
                    owner_d = pick_s[PW-1:0];
                    grant_d = onehot(pick_s[PW-1:0]);
                    timer_d = '0;
                    state_d = S_XFER;
                end else begin
                    state_d = S_ARB;
                end
            end
            S_XFER: begin
                if (i_req_valid[owner_q]) begin
                    data_d  = i_req_data[{owner_q, 3'b000} +: 8];
                    last_d  = i_req_last[owner_q];
                    timer_d = '0;
                    stb_d   = 1'b1;
                    state_d = S_STB;
                end else if ((HOLD_TIMEOUT != 0) && (timer_q == T_LAST)) begin
                    grant_d = '0;
                    ptr_d   = wrap_inc(owner_q);
                    timer_d = '0;
                    state_d = S_ARB;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_STB: begin
                state_d = S_WAIT_START;
            end
            S_WAIT_START: begin
                if (i_tx_busy) begin
                    state_d = S_WAIT_IDLE;
                end else begin
                    state_d = S_WAIT_START;
                end
            end
            S_WAIT_IDLE: begin
                if (!i_tx_busy && last_q) begin
                    grant_d = '0;
                    ptr_d   = wrap_inc(owner_q);
                    state_d = S_ARB;
                end else if (!i_tx_busy) begin
                    state_d = S_XFER;
                end else begin
                    state_d = S_WAIT_IDLE;
                end
            end
            default: begin
                grant_d = '0;
                state_d = S_ARB;
            end
        endcase
    end

    // Ready is offered only to the owner while waiting for its next byte
    always_comb begin
        o_req_ready = '0;
        if (state_q == S_XFER) begin
            o_req_ready = grant_q;
        end else begin
            o_req_ready = '0;
        end
    end

    // State and output registers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= S_ARB;
            ptr_q   <= '0;
            owner_q <= '0;
            grant_q <= '0;
            data_q  <= 8'h00;
            last_q  <= 1'b0;
            stb_q   <= 1'b0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            grant_q <= grant_d;
            data_q  <= data_d;
            last_q  <= last_d;
            stb_q   <= stb_d;
            timer_q <= timer_d;
        end
    end

    assign o_grant   = grant_q;
    assign o_tx_data = data_q;
    assign o_tx_stb  = stb_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: queued requesters, a busy-only uart_tx model, and a
// monitor that pops the expected (owner, byte) on every strobe.
module tb_uart_tx_arbiter;

    localparam int FRAME = 12;

    logic        clk;
    logic        i_reset;
    logic [3:0]  i_req_valid;
    logic [31:0] i_req_data;
    logic [3:0]  i_req_last;
    logic [3:0]  o_req_ready;
    logic [3:0]  o_grant;
    logic [7:0]  o_tx_data;
    logic        o_tx_stb;
    logic        tx_busy;

    int checks   = 0;
    int failures = 0;

    logic [8:0] rq [4][$];
    logic [9:0] exp_q [$];

    uart_tx_arbiter #(.NUM_REQ(4), .HOLD_TIMEOUT(16)) dut (
        .i_clk       (clk),
        .i_reset     (i_reset),
        .i_req_valid (i_req_valid),
        .i_req_data  (i_req_data),
        .i_req_last  (i_req_last),
        .o_req_ready (o_req_ready),
        .o_grant     (o_grant),
        .o_tx_data   (o_tx_data),
        .o_tx_stb    (o_tx_stb),
        .i_tx_busy   (tx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic rq_empty();
        return (rq[0].size() == 0) && (rq[1].size() == 0) && (rq[2].size() == 0) && (rq[3].size() == 0);
    endfunction

    task automatic expect_byte(input int k, input logic [7:0] b);
        exp_q.push_back({2'(k), b});
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, act, req);
        end
    endtask

    task automatic wait_drained(input string name);
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && o_grant == 4'b0000 && !tx_busy && rq_empty()) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 2000) begin
            failures++;
            $display("FAIL %s drain_timeout pending=%0d want=0", name, exp_q.size());
        end
    endtask

    // uart_tx stand-in: busy rises the cycle after the strobe and stays high for FRAME cycles
    initial begin
        int   busy_cnt;
        logic s;
        tx_busy  = 1'b0;
        busy_cnt = 0;
        forever begin
            @(negedge clk);
            s = o_tx_stb;
            @(posedge clk);
            #1;
            if (busy_cnt > 0) busy_cnt--;
            else if (s) busy_cnt = FRAME;
            tx_busy = (busy_cnt > 0);
        end
    end

    // Requester driver: present queue heads, pop whatever was accepted on the edge
    initial begin
        logic [3:0] acc;
        logic [8:0] h;
        i_req_valid = 4'b0000;
        i_req_data  = 32'h0000_0000;
        i_req_last  = 4'b0000;
        forever begin
            @(negedge clk);
            acc = i_req_valid & o_req_ready;
            @(posedge clk);
            #1;
            for (int k = 0; k < 4; k++) begin
                if (acc[k] && rq[k].size() > 0) void'(rq[k].pop_front());
                if (rq[k].size() > 0) begin
                    h                   = rq[k][0];
                    i_req_valid[k]      = 1'b1;
                    i_req_data[8*k +: 8] = h[7:0];
                    i_req_last[k]       = h[8];
                end else begin
                    i_req_valid[k] = 1'b0;
                    i_req_last[k]  = 1'b0;
                end
            end
        end
    end

    // Monitor: protocol checks every cycle, scoreboard pop on every strobe
    initial begin
        logic [9:0] e;
        logic [3:0] g;
        forever begin
            @(negedge clk);
            checks++;
            if ($countones(o_grant) > 1) begin
                failures++;
                $display("FAIL grant_onehot0 got=%b want=onehot0", o_grant);
            end
            checks++;
            if ((o_req_ready & ~o_grant) != 4'b0000 || $countones(o_req_ready) > 1) begin
                failures++;
                $display("FAIL ready_owner_only got=%b grant=%b", o_req_ready, o_grant);
            end
            if (o_tx_stb) begin
                check("stb_while_busy", {31'd0, tx_busy}, 32'd0);
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_stb got=%h want=none", o_tx_data);
                end else begin
                    e = exp_q.pop_front();
                    g = 4'b0001 << e[9:8];
                    if (o_tx_data !== e[7:0] || o_grant !== g) begin
                        failures++;
                        $display("FAIL stb_byte got=%h/%b want=%h/%b", o_tx_data, o_grant, e[7:0], g);
                    end
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        i_reset = 1'b1;
        for (int k = 0; k < 4; k++) rq[k].delete();
        @(negedge clk);
        @(negedge clk);
        i_reset = 1'b0;
    endtask

    initial begin
        int n;
        int cnt;
        i_reset = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_grant", {28'd0, o_grant}, 32'd0);
        check("reset_ready", {28'd0, o_req_ready}, 32'd0);
        check("reset_stb", {31'd0, o_tx_stb}, 32'd0);
        check("reset_data", {24'd0, o_tx_data}, 32'd0);
        i_reset = 1'b0;

        // 1: single requester, three-byte message
        rq[0].push_back({1'b0, 8'h3A}); rq[0].push_back({1'b0, 8'h30}); rq[0].push_back({1'b1, 8'h0D});
        expect_byte(0, 8'h3A); expect_byte(0, 8'h30); expect_byte(0, 8'h0D);
        wait_drained("t1");

        // 2: req0 and req2 contend with ptr=0; whole messages, no interleave
        do_reset();
        rq[0].push_back({1'b0, 8'h11}); rq[0].push_back({1'b1, 8'h22});
        rq[2].push_back({1'b0, 8'hA1}); rq[2].push_back({1'b0, 8'hA2}); rq[2].push_back({1'b1, 8'hA3});
        expect_byte(0, 8'h11); expect_byte(0, 8'h22);
        expect_byte(2, 8'hA1); expect_byte(2, 8'hA2); expect_byte(2, 8'hA3);
        wait_drained("t2");

        // 3: req1 stalls mid-message; grant revoked after 16 idle XFER cycles, ptr moves to 2
        rq[1].push_back({1'b0, 8'h55});
        expect_byte(1, 8'h55);
        n = 0;
        do begin @(negedge clk); n++; end while (!o_tx_stb && n < 200);
        check("t3_stb_seen", {31'd0, o_tx_stb}, 32'd1);
        rq[3].push_back({1'b1, 8'h66});
        rq[0].push_back({1'b1, 8'h01});
        expect_byte(3, 8'h66); expect_byte(0, 8'h01);
        cnt = 0;
        n   = 0;
        do begin
            @(negedge clk);
            n++;
            if (o_req_ready[1]) cnt++;
        end while (o_grant == 4'b0010 && n < 200);
        check("t3_hold_cycles", cnt, 32'd16);
        check("t3_grant_after_timeout", {28'd0, o_grant}, 32'd0);
        @(negedge clk);
        check("t3_next_owner", {28'd0, o_grant}, 32'b1000);
        wait_drained("t3");

        // 4: all four stream one-byte messages, ptr starts at 1
        for (int k = 0; k < 4; k++) begin
            rq[k].push_back({1'b1, 8'(8'h40 + k)});
            rq[k].push_back({1'b1, 8'(8'h50 + k)});
        end
        expect_byte(1, 8'h41); expect_byte(2, 8'h42); expect_byte(3, 8'h43); expect_byte(0, 8'h40);
        expect_byte(1, 8'h51); expect_byte(2, 8'h52); expect_byte(3, 8'h53); expect_byte(0, 8'h50);
        wait_drained("t4");

        // 5: reset while the 2nd byte is on the wire; no grant until uart goes idle
        rq[0].push_back({1'b0, 8'h77}); rq[0].push_back({1'b0, 8'h78}); rq[0].push_back({1'b1, 8'h79});
        expect_byte(0, 8'h77); expect_byte(0, 8'h78);
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin @(negedge clk); n++; end
        n = 0;
        while (!tx_busy && n < 20) begin @(negedge clk); n++; end
        check("t5_busy_before_reset", {31'd0, tx_busy}, 32'd1);
        @(negedge clk);
        i_reset = 1'b1;
        for (int k = 0; k < 4; k++) rq[k].delete();
        @(negedge clk);
        check("t5_reset_grant", {28'd0, o_grant}, 32'd0);
        check("t5_reset_data", {24'd0, o_tx_data}, 32'd0);
        check("t5_reset_stb", {31'd0, o_tx_stb}, 32'd0);
        i_reset = 1'b0;
        rq[1].push_back({1'b1, 8'h99});
        expect_byte(1, 8'h99);
        n = 0;
        while (tx_busy && n < 50) begin
            @(negedge clk);
            n++;
            if (tx_busy) check("t5_no_grant_while_busy", {28'd0, o_grant}, 32'd0);
        end
        wait_drained("t5");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
